// File: rtl/xyz_onchip_mem_burst_adapter.sv
// Avalon-MM burst slave that splits bursts into single-word accesses to a 1-cycle-latency
// on-chip RAM, wrapping addresses modulo DEPTH and returning read data with readdatavalid.
module xyz_onchip_mem_burst_adapter #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 10000,
    parameter int unsigned BURST_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic [BURST_W-1:0]  s_burstcount,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [DATA_W-1:0]   s_writedata,
    input  logic [DATA_W/8-1:0] s_byteenable,
    output logic                s_waitrequest,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                s_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic                wrap_pulse
);

    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned MAX_LEN = 2 ** (BURST_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t              state;
    logic [BURST_W-1:0]  remaining;
    logic [ADDR_W-1:0]   next_addr;
    logic                next_wrap;
    logic                rd_pend;

    logic [BURST_W-1:0]  cmd_len;
    logic [ADDR_W-1:0]   start_addr;
    logic [ADDR_W-1:0]   start_inc;
    logic                start_last;
    logic [ADDR_W-1:0]   next_inc;
    logic                next_last;

    // Command decode: clamp burst length, fold start address into range, precompute increments
    always_comb begin
        cmd_len = s_burstcount;
        if (s_burstcount == '0) begin
            cmd_len = BURST_W'(1);
        end else if (s_burstcount > BURST_W'(MAX_LEN)) begin
            cmd_len = BURST_W'(MAX_LEN);
        end

        start_addr = s_address;
        if (s_address >= ADDR_W'(DEPTH)) begin
            start_addr = s_address - ADDR_W'(DEPTH);
        end

        start_last = (start_addr == ADDR_W'(DEPTH - 1));
        start_inc  = start_last ? '0 : start_addr + ADDR_W'(1);
        next_last  = (next_addr == ADDR_W'(DEPTH - 1));
        next_inc   = next_last ? '0 : next_addr + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            remaining       <= '0;
            next_addr       <= '0;
            next_wrap       <= 1'b0;
            rd_pend         <= 1'b0;
            s_waitrequest   <= 1'b0;
            s_readdata      <= '0;
            s_readdatavalid <= 1'b0;
            m_address       <= '0;
            m_chipselect    <= 1'b0;
            m_write         <= 1'b0;
            m_byteenable    <= '0;
            m_writedata     <= '0;
            wrap_pulse      <= 1'b0;
        end else begin
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            wrap_pulse   <= 1'b0;

            // RAM answers one cycle after the read is presented; register it once more for the slave
            rd_pend         <= m_chipselect & ~m_write;
            s_readdatavalid <= rd_pend;
            if (rd_pend) begin
                s_readdata <= m_readdata;
            end

            case (state)
                IDLE: begin
                    if (s_write) begin
                        m_chipselect <= 1'b1;
                        m_write      <= 1'b1;
                        m_address    <= start_addr;
                        m_writedata  <= s_writedata;
                        m_byteenable <= s_byteenable;
                        next_addr    <= start_inc;
                        next_wrap    <= start_last;
                        remaining    <= cmd_len - BURST_W'(1);
                        if (cmd_len > BURST_W'(1)) begin
                            state <= WR;
                        end
                    end else if (s_read) begin
                        // First read issues on the accept edge so issues land at T+1..T+L
                        m_chipselect  <= 1'b1;
                        m_address     <= start_addr;
                        next_addr     <= start_inc;
                        next_wrap     <= start_last;
                        remaining     <= cmd_len - BURST_W'(1);
                        s_waitrequest <= 1'b1;
                        state         <= RD;
                    end
                end

                WR: begin
                    if (s_write) begin
                        m_chipselect <= 1'b1;
                        m_write      <= 1'b1;
                        m_address    <= next_addr;
                        m_writedata  <= s_writedata;
                        m_byteenable <= s_byteenable;
                        wrap_pulse   <= next_wrap;
                        next_addr    <= next_inc;
                        next_wrap    <= next_last;
                        remaining    <= remaining - BURST_W'(1);
                        if (remaining == BURST_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end

                RD: begin
                    if (remaining != '0) begin
                        m_chipselect <= 1'b1;
                        m_address    <= next_addr;
                        wrap_pulse   <= next_wrap;
                        next_addr    <= next_inc;
                        next_wrap    <= next_last;
                        remaining    <= remaining - BURST_W'(1);
                    end else begin
                        s_waitrequest <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    s_waitrequest <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xyz_onchip_mem_burst_adapter.sv
// Directed bench for the burst adapter with a behavioural 1-cycle-latency RAM behind it.
module tb_xyz_onchip_mem_burst_adapter;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 10000;
    localparam int unsigned BURST_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] s_address;
    logic [BURST_W-1:0] s_burstcount;
    logic              s_read;
    logic              s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [3:0]        s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              wrap_pulse;

    int errors = 0;
    int checks = 0;

    xyz_onchip_mem_burst_adapter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_W(BURST_W)
    ) dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_burstcount(s_burstcount),
        .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: byte-enabled write, registered read
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (m_chipselect) begin
            if (m_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_byteenable[b]) mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
                end
            end else begin
                m_readdata <= mem[m_address];
            end
        end
    end

    // Access log sampled mid-cycle
    int                acc_count = 0;
    int                wrap_count = 0;
    logic [ADDR_W-1:0] wrap_addr;
    logic [ADDR_W-1:0] wlog_addr [$];
    logic [DATA_W-1:0] wlog_data [$];
    logic              wlog_wrap [$];
    always @(negedge clk) begin
        if (m_chipselect) begin
            acc_count = acc_count + 1;
            if (m_write) begin
                wlog_addr.push_back(m_address);
                wlog_data.push_back(m_writedata);
                wlog_wrap.push_back(wrap_pulse);
            end
        end
        if (wrap_pulse) begin
            wrap_count = wrap_count + 1;
            wrap_addr  = m_address;
        end
    end

    logic [DATA_W-1:0] rd_data [$];
    int rd_wait, rd_first, rd_last, rd_gap;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wbeat(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc,
                         input logic [DATA_W-1:0] d, input logic [3:0] be);
        s_write = 1'b1; s_address = a; s_burstcount = bc; s_writedata = d; s_byteenable = be;
        tick();
        s_write = 1'b0;
    endtask

    // Issue one read command and record what comes back over a fixed window
    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc, input int budget);
        rd_data.delete();
        rd_wait = 0; rd_first = -1; rd_last = -1; rd_gap = 0;
        s_read = 1'b1; s_address = a; s_burstcount = bc;
        tick();
        s_read = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            if (s_waitrequest) rd_wait++;
            if (s_readdatavalid) begin
                if (rd_first < 0) rd_first = i;
                else if (i != rd_last + 1) rd_gap = 1;
                rd_last = i;
                rd_data.push_back(s_readdata);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; s_read = 1'b0; s_write = 1'b0;
        s_address = '0; s_burstcount = '0; s_writedata = '0; s_byteenable = '0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq got %b want 0", s_waitrequest); end
        checks++; if (s_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b want 0", s_readdatavalid); end
        checks++; if (s_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", s_readdata); end
        checks++; if ({m_chipselect, m_write, wrap_pulse} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b want 000", {m_chipselect, m_write, wrap_pulse}); end
        checks++; if ({m_address, m_byteenable, m_writedata} !== '0) begin errors++; $display("FAIL reset_mbus got %h want 0", {m_address, m_byteenable, m_writedata}); end
        tick();
    endtask

    task automatic test_single();
        wbeat(14'h0010, 8'd1, 32'hDEADBEEF, 4'hF);
        checks++; if ({m_chipselect, m_write} !== 2'b11) begin errors++; $display("FAIL single_wr_strobe got %b want 11", {m_chipselect, m_write}); end
        checks++; if (m_address !== 14'h0010) begin errors++; $display("FAIL single_wr_addr got %h want 0010", m_address); end
        checks++; if (m_writedata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wr_data got %h want deadbeef", m_writedata); end
        do_read(14'h0010, 8'd1, 6);
        checks++; if (rd_first !== 3) begin errors++; $display("FAIL single_rd_latency got %0d want 3", rd_first); end
        checks++; if (rd_data.size() !== 1) begin errors++; $display("FAIL single_rd_count got %0d want 1", rd_data.size()); end
        else begin
            checks++; if (rd_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd_data got %h want deadbeef", rd_data[0]); end
        end
        checks++; if (rd_wait !== 1) begin errors++; $display("FAIL single_rd_wait got %0d want 1", rd_wait); end
    endtask

    task automatic test_burst_idle_beat();
        wlog_addr.delete(); wlog_data.delete(); wlog_wrap.delete();
        wbeat(14'h0100, 8'd4, 32'd1, 4'hF);
        wbeat(14'h0000, 8'd0, 32'd2, 4'hF);
        tick();
        wbeat(14'h0000, 8'd0, 32'd3, 4'hF);
        wbeat(14'h0000, 8'd0, 32'd4, 4'hF);
        tick();
        checks++; if (wlog_addr.size() !== 4) begin errors++; $display("FAIL burst_wr_count got %0d want 4", wlog_addr.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wlog_addr[i] !== 14'(14'h0100 + i) || wlog_data[i] !== 32'(i + 1)) begin
                    errors++; $display("FAIL burst_wr_beat%0d got %h/%h want %h/%h", i, wlog_addr[i], wlog_data[i], 14'(14'h0100 + i), i + 1);
                end
            end
        end
        do_read(14'h0100, 8'd4, 10);
        checks++; if (rd_wait !== 4) begin errors++; $display("FAIL burst_rd_wait got %0d want 4", rd_wait); end
        checks++; if (rd_first !== 3 || rd_gap !== 0) begin errors++; $display("FAIL burst_rd_timing got first=%0d gap=%0d want 3/0", rd_first, rd_gap); end
        checks++; if (rd_data.size() !== 4) begin errors++; $display("FAIL burst_rd_count got %0d want 4", rd_data.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (rd_data[i] !== 32'(i + 1)) begin errors++; $display("FAIL burst_rd_word%0d got %h want %h", i, rd_data[i], i + 1); end
            end
        end
    endtask

    task automatic test_wrap();
        int w0;
        wlog_addr.delete(); wlog_data.delete(); wlog_wrap.delete();
        wbeat(14'd9998, 8'd3, 32'hA0A0A0A0, 4'hF);
        wbeat(14'd0, 8'd0, 32'hB1B1B1B1, 4'hF);
        wbeat(14'd0, 8'd0, 32'hC2C2C2C2, 4'hF);
        tick();
        checks++; if (wlog_addr.size() !== 3) begin errors++; $display("FAIL wrap_wr_count got %0d want 3", wlog_addr.size()); end
        else begin
            checks++; if (wlog_addr[0] !== 14'd9998 || wlog_addr[1] !== 14'd9999 || wlog_addr[2] !== 14'd0) begin
                errors++; $display("FAIL wrap_wr_addr got %0d,%0d,%0d want 9998,9999,0", wlog_addr[0], wlog_addr[1], wlog_addr[2]); end
            checks++; if ({wlog_wrap[0], wlog_wrap[1], wlog_wrap[2]} !== 3'b001) begin
                errors++; $display("FAIL wrap_wr_pulse got %b want 001", {wlog_wrap[0], wlog_wrap[1], wlog_wrap[2]}); end
        end
        w0 = wrap_count;
        do_read(14'd9998, 8'd3, 8);
        checks++; if (wrap_count - w0 !== 1 || wrap_addr !== 14'd0) begin errors++; $display("FAIL wrap_rd_pulse got n=%0d addr=%0d want 1/0", wrap_count - w0, wrap_addr); end
        checks++; if (rd_data.size() !== 3) begin errors++; $display("FAIL wrap_rd_count got %0d want 3", rd_data.size()); end
        else begin
            checks++; if (rd_data[0] !== 32'hA0A0A0A0 || rd_data[1] !== 32'hB1B1B1B1 || rd_data[2] !== 32'hC2C2C2C2) begin
                errors++; $display("FAIL wrap_rd_data got %h %h %h want a0a0a0a0 b1b1b1b1 c2c2c2c2", rd_data[0], rd_data[1], rd_data[2]); end
        end
    endtask

    task automatic test_partial();
        wbeat(14'h0200, 8'd1, 32'hFFFFFFFF, 4'hF);
        wbeat(14'h0200, 8'd1, 32'h0000AAAA, 4'h3);
        do_read(14'h0200, 8'd1, 5);
        checks++; if (rd_data.size() !== 1) begin errors++; $display("FAIL partial_count got %0d want 1", rd_data.size()); end
        else begin
            checks++; if (rd_data[0] !== 32'hFFFFAAAA) begin errors++; $display("FAIL partial_data got %h want ffffaaaa", rd_data[0]); end
        end
    endtask

    task automatic test_priority_len0();
        int a0;
        int v;
        a0 = acc_count; v = 0;
        s_read = 1'b1; s_write = 1'b1; s_address = 14'h0300; s_burstcount = 8'd0;
        s_writedata = 32'h12345678; s_byteenable = 4'hF;
        tick();
        s_read = 1'b0; s_write = 1'b0;
        checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("FAIL prio_waitreq got %b want 0", s_waitrequest); end
        checks++; if ({m_chipselect, m_write} !== 2'b11 || m_address !== 14'h0300) begin
            errors++; $display("FAIL prio_write got cs/wr=%b addr=%h want 11/0300", {m_chipselect, m_write}, m_address); end
        for (int i = 0; i < 5; i++) begin
            if (s_readdatavalid) v++;
            tick();
        end
        checks++; if (acc_count - a0 !== 1) begin errors++; $display("FAIL len0_accesses got %0d want 1", acc_count - a0); end
        checks++; if (v !== 0) begin errors++; $display("FAIL prio_no_read got %0d valids want 0", v); end
        do_read(14'h0300, 8'd1, 5);
        checks++; if (rd_data.size() !== 1 || rd_data[0] !== 32'h12345678) begin
            errors++; $display("FAIL prio_readback got n=%0d want 1 word 12345678", rd_data.size()); end
    endtask

    task automatic test_addr_mod_clamp();
        wbeat(14'd10005, 8'd1, 32'h5555AAAA, 4'hF);
        checks++; if (m_address !== 14'd5) begin errors++; $display("FAIL addr_mod got %0d want 5", m_address); end
        tick();
        do_read(14'd0, 8'd200, 136);
        checks++; if (rd_data.size() !== 128 || rd_wait !== 128 || rd_gap !== 0) begin
            errors++; $display("FAIL clamp got n=%0d wait=%0d gap=%0d want 128/128/0", rd_data.size(), rd_wait, rd_gap); end
        else begin
            checks++; if (rd_data[5] !== 32'h5555AAAA) begin errors++; $display("FAIL clamp_word5 got %h want 5555aaaa", rd_data[5]); end
        end
    endtask

    task automatic test_reset_midread();
        int v;
        int w;
        wbeat(14'h0400, 8'd8, 32'h400, 4'hF);
        for (int i = 1; i < 8; i++) wbeat(14'h0, 8'd0, 32'(32'h400 + i), 4'hF);
        tick();
        s_read = 1'b1; s_address = 14'h0400; s_burstcount = 8'd8;
        tick();
        s_read = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({s_readdatavalid, s_waitrequest, m_chipselect} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_outputs got rdv/wait/cs=%b want 000", {s_readdatavalid, s_waitrequest, m_chipselect}); end
        v = 0; w = 0;
        for (int i = 0; i < 8; i++) begin
            if (s_readdatavalid) v++;
            if (s_waitrequest) w++;
            tick();
        end
        checks++; if (v !== 0 || w !== 0) begin errors++; $display("FAIL rst_mid_quiet got valids=%0d waits=%0d want 0/0", v, w); end
        do_read(14'h0402, 8'd2, 7);
        checks++; if (rd_data.size() !== 2) begin errors++; $display("FAIL rst_mid_next_count got %0d want 2", rd_data.size()); end
        else begin
            checks++; if (rd_data[0] !== 32'h402 || rd_data[1] !== 32'h403) begin
                errors++; $display("FAIL rst_mid_next_data got %h %h want 402 403", rd_data[0], rd_data[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_idle_beat();
        test_wrap();
        test_partial();
        test_priority_len0();
        test_addr_mod_clamp();
        test_reset_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
